graph_bfs_path: RTL
===================

# graph_bfs_path

Parametrised breadth-first shortest-path engine for the roadmap planner. It sweeps an edge list held in external RAM once per BFS level, skipping edges rejected by the collision checker (`edgeMask`), and records a parent pointer per node. It then streams the node chain from `startPose` to `endPose` over a valid/ready port. It sits between the collision-check stage, which supplies `edgeMask`, and the trajectory stage, which consumes the path.

## Interface
- `N_NODE`, default 66: number of poses (nodes).
- `N_EDGE`, default 1034: number of edges (RAM words).
- `MAX_LEVEL`, default 10: maximum path length in edges.
- `NODE_W`, default 8: pose index width; requires 2^NODE_W ≥ N_NODE.
- `ADDR_W`, default 11: RAM address width; requires 2^ADDR_W ≥ N_EDGE.
- `CLK` in 1: clock.
- `RST_n` in 1: reset, synchronous, active-low; clock CLK.
- `start` in 1: one-cycle request; ignored unless IDLE.
- `startPose` in NODE_W: path source; sampled on `start`.
- `endPose` in NODE_W: path target; sampled on `start`.
- `edgeMask` in N_EDGE: bit i=1 means edge i is blocked; sampled on `start`.
- `ramAddress` out ADDR_W: edge RAM read address.
- `ramData` in 2*NODE_W: edge word, [2*NODE_W-1:NODE_W]=firstPose, [NODE_W-1:0]=secondPose; 1-cycle read latency.
- `busy` out 1: high from the cycle after `start` until `done`.
- `done` out 1: one-cycle pulse at end of request.
- `found` out 1: path exists; valid with `done`, held until the next `start`.
- `pathLen` out 4+: edge count of the path; width clog2(MAX_LEVEL+1); held like `found`.
- `pathValid` out 1, `pathPose` out NODE_W, `pathReady` in 1: path stream.

## Operation
- States: IDLE, INIT, SCAN, LEVEL_END, TRACE, FINISH.
- IDLE, on `start`: latch poses and mask; go to INIT.
- INIT:
  - If either pose ≥ N_NODE: `found`=0, go to FINISH.
  - If startPose==endPose: `pathLen`=0, go to TRACE.
  - Otherwise: visited={endPose}, frontier={endPose}, next=0, level=0, go to SCAN. The search is rooted at the target, so parent chains walk start→end.
- SCAN: issue addresses 0..N_EDGE-1, one per cycle. Edge i, with data arriving one cycle later, is taken when all of the following hold:
  - mask[i]=0;
  - firstPose≠secondPose, and both < N_NODE;
  - exactly one endpoint is in frontier;
  - the other endpoint is in neither visited nor next.
- A taken edge sets next[other], and parent[other] gets the frontier endpoint. When several edges reach the same node in one level, the lowest address wins.
- LEVEL_END, checked in this order:
  1. visited|next contains startPose: `pathLen`=level+1, go to TRACE.
  2. next==0 or level+1==MAX_LEVEL: `found`=0, go to FINISH.
  3. Otherwise: visited|=next, frontier=next, next=0, level++, return to SCAN from address 0.
- TRACE: ptr=startPose; drive `pathValid`=1, `pathPose`=ptr.
  - On a handshake with ptr==endPose: `found`=1, go to FINISH.
  - On any other handshake: ptr=parent[ptr].
- FINISH: pulse `done`, drop `busy`, go to IDLE.
- `start` while busy is dropped. Reset in any state returns to IDLE immediately; a partial stream is abandoned.

## Timing
- Reset values: `ramAddress`=0, `busy`=0, `done`=0, `found`=0, `pathLen`=0, `pathValid`=0, `pathPose`=0. Parent table contents are don't-care.
- INIT takes 1 cycle.
- Each level takes N_EDGE+2 cycles: N_EDGE issue cycles, 1 drain cycle for the last data, and LEVEL_END.
- Path found at level L (L+1 edges): `pathValid` first rises 2+(L+1)(N_EDGE+2) cycles after `start`.
- Each path pose is held until `pathReady`; with `pathReady` tied high, TRACE emits one pose per cycle.
- `done` asserts the cycle after the last handshake, or directly after INIT/LEVEL_END on failure.
- `pathValid` must not depend combinationally on `pathReady`.
- `ramAddress` holds its last value outside SCAN.

## Structure
- Package `graph_pkg`:
  - state enum;
  - `RAM_LAT`=1;
  - `clog2` function;
  - edge-word field extraction function.
- Sub-module `graph_parent_table`: N_NODE×NODE_W register file with one write port (SCAN) and one asynchronous read port (TRACE).
- visited, frontier and next are N_NODE-bit vectors in the top level.

## Test plan
Parameters: N_NODE=8, N_EDGE=16, MAX_LEVEL=4.
- Chain edges 0-1, 1-2, 2-3, all unmasked; start=0, end=3 → stream 0,1,2,3; `found`=1, `pathLen`=3; first `pathValid` at cycle 2+3·18=56.
- Add shortcut edge 0-3 at address 9 → stream 0,3; `pathLen`=1. Then mask bit 9 → back to 0,1,2,3.
- Two equal paths 0-1-3 (addresses 2, 5) and 0-2-3 (addresses 4, 7) → parent of 0 comes from address 2, giving stream 0,1,3.
- Disconnected node 5 as end → `done` with `found`=0, no `pathValid`. A 5-edge chain with MAX_LEVEL=4 → `found`=0 after 4 levels.
- start=end=6 → single pose 6, `pathLen`=0. startPose=9 → immediate fail.
- `pathReady` toggled randomly: poses unchanged while stalled. `RST_n` low mid-SCAN → all outputs return to reset values the next cycle; a new `start` succeeds.

Source files
------------

// File: rtl/graph_pkg.sv
// rtl/graph_pkg.sv - shared types and helpers for the BFS path engine
package graph_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    SCAN,
    LEVEL_END,
    TRACE,
    FINISH
  } state_e;

  localparam int RAM_LAT    = 1;
  localparam int MAX_NODE_W = 16;
  localparam int EW_MAX     = 2 * MAX_NODE_W;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // first=1 selects the upper pose of an edge word, first=0 the lower one
  function automatic logic [MAX_NODE_W-1:0] edge_pose(input logic [EW_MAX-1:0] word,
                                                      input int node_w,
                                                      input logic first);
    logic [EW_MAX-1:0] sh;
    logic [EW_MAX-1:0] msk;
    sh  = first ? (word >> node_w) : word;
    msk = ~({EW_MAX{1'b1}} << node_w);
    return MAX_NODE_W'(sh & msk);
  endfunction

endpackage

// File: rtl/graph_parent_table.sv
// rtl/graph_parent_table.sv - per-node parent pointer register file
module graph_parent_table #(
  parameter int N_NODE = 66,
  parameter int NODE_W = 8
) (
  input  logic              CLK,
  input  logic              we_i,
  input  logic [NODE_W-1:0] waddr_i,
  input  logic [NODE_W-1:0] wdata_i,
  input  logic [NODE_W-1:0] raddr_i,
  output logic [NODE_W-1:0] rdata_o
);

  logic [NODE_W-1:0] mem_q [N_NODE];

  always_ff @(posedge CLK) begin
    for (int n = 0; n < N_NODE; n++) begin
      if (we_i && waddr_i == NODE_W'(n)) mem_q[n] <= wdata_i;
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int n = 0; n < N_NODE; n++) begin
      if (raddr_i == NODE_W'(n)) rdata_o = mem_q[n];
    end
  end

endmodule

// File: rtl/graph_bfs_path.sv
// rtl/graph_bfs_path.sv - level-by-level BFS over an edge RAM, streams start->end pose chain
module graph_bfs_path
  import graph_pkg::*;
#(
  parameter int N_NODE    = 66,
  parameter int N_EDGE    = 1034,
  parameter int MAX_LEVEL = 10,
  parameter int NODE_W    = 8,
  parameter int ADDR_W    = 11
) (
  input  logic                               CLK,
  input  logic                               RST_n,
  input  logic                               start,
  input  logic [NODE_W-1:0]                  startPose,
  input  logic [NODE_W-1:0]                  endPose,
  input  logic [N_EDGE-1:0]                  edgeMask,
  output logic [ADDR_W-1:0]                  ramAddress,
  input  logic [2*NODE_W-1:0]                ramData,
  output logic                               busy,
  output logic                               done,
  output logic                               found,
  output logic [clog2(MAX_LEVEL+1)-1:0]      pathLen,
  output logic                               pathValid,
  output logic [NODE_W-1:0]                  pathPose,
  input  logic                               pathReady
);

  localparam int LEN_W = clog2(MAX_LEVEL + 1);
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [NODE_W:0]    NODE_LIM  = (NODE_W+1)'(N_NODE);
  localparam logic [CNT_W-1:0]   SCAN_LAST = CNT_W'(N_EDGE + RAM_LAT - 1);

  state_e              state_q;
  logic [NODE_W-1:0]   src_q, dst_q;
  logic [N_EDGE-1:0]   mask_q;
  logic [N_NODE-1:0]   visited_q, frontier_q, next_q, next_d;
  logic [LEN_W-1:0]    level_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                dvld_q;
  logic [ADDR_W-1:0]   daddr_q;
  logic [ADDR_W-1:0]   ramAddress_q;
  logic                busy_q, done_q, found_q, pathValid_q;
  logic [LEN_W-1:0]    pathLen_q;
  logic [NODE_W-1:0]   pathPose_q;

  logic [NODE_W-1:0]   first_pose, second_pose, other_pose, from_pose, parent_pose;
  logic                first_in, second_in, take;

  function automatic logic bit_of(input logic [N_NODE-1:0] v, input logic [NODE_W-1:0] idx);
    logic r;
    r = 1'b0;
    for (int n = 0; n < N_NODE; n++) begin
      if (idx == NODE_W'(n)) r = v[n];
    end
    return r;
  endfunction

  function automatic logic [N_NODE-1:0] onehot(input logic [NODE_W-1:0] idx);
    logic [N_NODE-1:0] r;
    r = '0;
    for (int n = 0; n < N_NODE; n++) begin
      if (idx == NODE_W'(n)) r[n] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic in_range(input logic [NODE_W-1:0] p);
    return {1'b0, p} < NODE_LIM;
  endfunction

  // Edge acceptance: data on ramData belongs to the address issued the previous cycle
  always_comb begin
    first_pose  = NODE_W'(edge_pose(EW_MAX'(ramData), NODE_W, 1'b1));
    second_pose = NODE_W'(edge_pose(EW_MAX'(ramData), NODE_W, 1'b0));
    first_in    = bit_of(frontier_q, first_pose);
    second_in   = bit_of(frontier_q, second_pose);
    other_pose  = first_in ? second_pose : first_pose;
    from_pose   = first_in ? first_pose : second_pose;
    take        = (state_q == SCAN) && dvld_q && !mask_q[daddr_q] &&
                  (first_pose != second_pose) &&
                  in_range(first_pose) && in_range(second_pose) &&
                  (first_in ^ second_in) &&
                  !bit_of(visited_q | next_q, other_pose);
    next_d      = take ? (next_q | onehot(other_pose)) : next_q;
  end

  graph_parent_table #(
    .N_NODE (N_NODE),
    .NODE_W (NODE_W)
  ) u_parent (
    .CLK     (CLK),
    .we_i    (take),
    .waddr_i (other_pose),
    .wdata_i (from_pose),
    .raddr_i (pathPose_q),
    .rdata_o (parent_pose)
  );

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_q      <= IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      mask_q       <= '0;
      visited_q    <= '0;
      frontier_q   <= '0;
      next_q       <= '0;
      level_q      <= '0;
      cnt_q        <= '0;
      dvld_q       <= 1'b0;
      daddr_q      <= '0;
      ramAddress_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      found_q      <= 1'b0;
      pathLen_q    <= '0;
      pathValid_q  <= 1'b0;
      pathPose_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            src_q     <= startPose;
            dst_q     <= endPose;
            mask_q    <= edgeMask;
            busy_q    <= 1'b1;
            found_q   <= 1'b0;
            pathLen_q <= '0;
            state_q   <= INIT;
          end
        end
        INIT: begin
          if (!in_range(src_q) || !in_range(dst_q)) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= FINISH;
          end else if (src_q == dst_q) begin
            pathLen_q   <= '0;
            pathValid_q <= 1'b1;
            pathPose_q  <= src_q;
            state_q     <= TRACE;
          end else begin
            // rooted at the target so parent chains lead from start toward end
            visited_q    <= onehot(dst_q);
            frontier_q   <= onehot(dst_q);
            next_q       <= '0;
            level_q      <= '0;
            cnt_q        <= '0;
            dvld_q       <= 1'b0;
            ramAddress_q <= '0;
            state_q      <= SCAN;
          end
        end
        SCAN: begin
          next_q  <= next_d;
          dvld_q  <= (cnt_q < CNT_W'(N_EDGE));
          daddr_q <= ramAddress_q;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q < CNT_W'(N_EDGE - 1)) ramAddress_q <= ramAddress_q + ADDR_W'(1);
          if (cnt_q == SCAN_LAST) state_q <= LEVEL_END;
        end
        LEVEL_END: begin
          if (bit_of(visited_q | next_q, src_q)) begin
            pathLen_q   <= level_q + LEN_W'(1);
            pathValid_q <= 1'b1;
            pathPose_q  <= src_q;
            state_q     <= TRACE;
          end else if (next_q == '0 || (level_q + LEN_W'(1)) == LEN_W'(MAX_LEVEL)) begin
            found_q <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= FINISH;
          end else begin
            visited_q    <= visited_q | next_q;
            frontier_q   <= next_q;
            next_q       <= '0;
            level_q      <= level_q + LEN_W'(1);
            cnt_q        <= '0;
            dvld_q       <= 1'b0;
            ramAddress_q <= '0;
            state_q      <= SCAN;
          end
        end
        TRACE: begin
          if (pathReady) begin
            if (pathPose_q == dst_q) begin
              found_q     <= 1'b1;
              pathValid_q <= 1'b0;
              done_q      <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= FINISH;
            end else begin
              pathPose_q <= parent_pose;
            end
          end
        end
        FINISH: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ramAddress = ramAddress_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign found      = found_q;
  assign pathLen    = pathLen_q;
  assign pathValid  = pathValid_q;
  assign pathPose   = pathPose_q;

endmodule
